// File: rtl/pointer_file.sv
// Bank of NUM_PTRS address pointers, loaded byte-wise from the data bus, with one
// register-selected pointer acting as instruction pointer and any pointer usable as data pointer.
module pointer_file #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PTRS   = 4,
    localparam int IDX_W     = $clog2(NUM_PTRS),
    localparam int NBYTES    = ADDR_WIDTH / DATA_WIDTH,
    localparam int BSEL_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  we,
    input  logic [IDX_W-1:0]      w_idx,
    input  logic [BSEL_W-1:0]     w_byte,
    input  logic                  inc_ip,
    input  logic                  addr_dp,
    input  logic [IDX_W-1:0]      dp_idx,
    input  logic                  post_inc,
    input  logic                  set_ip,
    input  logic [IDX_W-1:0]      new_ip,
    input  logic                  clr_wrap,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic [BSEL_W-1:0]     rd_byte,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [IDX_W-1:0]      ip_idx,
    output logic                  ip_wrap
);

    logic [ADDR_WIDTH-1:0] ptr     [NUM_PTRS];
    logic [ADDR_WIDTH-1:0] ptr_nxt [NUM_PTRS];
    logic [ADDR_WIDTH-1:0] ip_val;
    logic [ADDR_WIDTH-1:0] rd_val;
    logic [IDX_W-1:0]      ip_nxt;
    logic                  wrap_nxt;
    logic                  lane_ok;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] v);
        return v + ADDR_WIDTH'(1);
    endfunction

    assign ip_val = ptr[ip_idx];
    assign rd_val = ptr[rd_idx];
    assign addr   = addr_dp ? ptr[dp_idx] : ip_val;

    // Lanes past the top byte read as zero and ignore writes.
    always_comb begin
        data_out = '0;
        lane_ok  = 1'b0;
        for (int b = 0; b < NBYTES; b++) begin
            if (rd_byte == BSEL_W'(b))
                data_out = rd_val[b*DATA_WIDTH +: DATA_WIDTH];
            if (w_byte == BSEL_W'(b))
                lane_ok = 1'b1;
        end
    end

    // All updates use pre-edge state; a byte write overrides any increment of the same
    // pointer, and IP/post increments landing on one pointer merge into a single +1.
    always_comb begin
        for (int i = 0; i < NUM_PTRS; i++) begin
            ptr_nxt[i] = ptr[i];
            if (we && lane_ok && (w_idx == IDX_W'(i))) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_byte == BSEL_W'(b))
                        ptr_nxt[i][b*DATA_WIDTH +: DATA_WIDTH] = di;
                end
            end else if ((inc_ip && (ip_idx == IDX_W'(i))) ||
                         (post_inc && addr_dp && (dp_idx == IDX_W'(i)))) begin
                ptr_nxt[i] = ptr_inc(ptr[i]);
            end
        end
    end

    // Wrap detection looks at the IP increment request, even if a write suppresses it.
    always_comb begin
        ip_nxt   = set_ip ? new_ip : ip_idx;
        wrap_nxt = ip_wrap;
        if (clr_wrap)
            wrap_nxt = 1'b0;
        if (inc_ip && (ip_val == {ADDR_WIDTH{1'b1}}))
            wrap_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PTRS; i++)
                ptr[i] <= '0;
            ip_idx  <= '0;
            ip_wrap <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PTRS; i++)
                ptr[i] <= ptr_nxt[i];
            ip_idx  <= ip_nxt;
            ip_wrap <= wrap_nxt;
        end
    end

endmodule
